// File: rtl/fir_sink.sv
// fir_sink: requantises the 19-bit filter result to 8 bits with round-half-up
// and saturation, then buffers the samples in a small FIFO for a downstream
// consumer. The filter side cannot be stalled, so when the FIFO is full the
// incoming sample is dropped and a sticky overflow flag records the loss.
// A simultaneous pop makes room on the same edge, so a full FIFO that is being
// drained never drops samples.

module fir_sink #(
  parameter int unsigned SHIFT = 3,  // right shift before requantisation, 1..11
  parameter int unsigned DEPTH = 8   // FIFO depth, power of two, 2..16
) (
  input  logic        clock,
  input  logic        reset,         // asynchronous, active low
  input  logic        valid_in,
  input  logic [18:0] y,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clear_ovf,
  output logic [4:0]  level,
  output logic [15:0] count,
  output logic        overflow
);

  // Pointer width; DEPTH is a power of two so the pointers wrap naturally.
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  // Rounding constant: half of one output LSB, expressed at 20-bit width.
  localparam logic [19:0] ROUND_C = 20'(20'd1 << (SHIFT - 1));

  // Requantise one filter result: add the rounding constant at 20 bits so the
  // carry out of bit 18 is kept, shift, then clamp to the 8-bit range.
  function automatic logic [7:0] requant(input logic [18:0] val);
    logic [19:0] wide;
    logic [19:0] shifted;
    wide    = {1'b0, val} + ROUND_C;
    shifted = wide >> SHIFT;
    if (shifted > 20'd255) begin
      requant = 8'hFF;
    end else begin
      requant = shifted[7:0];
    end
  endfunction

  // Sample storage; contents need no reset because level gates visibility.
  logic [7:0]    mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [4:0]    level_q;
  logic [4:0]    level_d;
  logic [15:0]   count_q;
  logic [15:0]   count_d;
  logic          ovf_q;
  logic          ovf_d;

  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          not_empty_s;
  logic          full_s;
  logic [7:0]    wdata_s;

  // Handshake decode: a pop frees a slot on the same edge, so a full FIFO
  // still accepts a push when it is also being read.
  always_comb begin
    not_empty_s = (level_q != 5'd0);
    full_s      = (level_q == DEPTH_L);
    pop_s       = not_empty_s && out_ready;
    push_s      = valid_in && (!full_s || pop_s);
    drop_s      = valid_in && !push_s;
    wdata_s     = requant(y);
  end

  // Next-state logic for pointers, occupancy, push counter and overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + 16'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    // A drop on the same edge as a clear request must leave the flag set.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state register; reset empties the FIFO immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 5'd0;
      count_q  <= 16'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage write port: the requantised sample lands at the write pointer.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  // Output view: the head entry is read straight from storage flops, so there
  // is no combinational path from y; forced to zero while the FIFO is empty,
  // which also covers the reset state.
  always_comb begin
    out_valid = not_empty_s;
    if (not_empty_s) begin
      out_data = mem_q[rd_ptr_q];
    end else begin
      out_data = 8'd0;
    end
    level    = level_q;
    count    = count_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_fir_sink.sv
// Bench for fir_sink: a queue-based scoreboard models the FIFO; expected
// samples are pushed when stimulus is driven and popped when the DUT presents
// them with out_ready high.

module tb_fir_sink;

  localparam int unsigned SHIFT = 3;
  localparam int unsigned DEPTH = 8;

  logic        clock;
  logic        reset;
  logic        valid_in;
  logic [18:0] y;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clear_ovf;
  logic [4:0]  level;
  logic [15:0] count;
  logic        overflow;

  fir_sink #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (valid_in),
    .y         (y),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clear_ovf (clear_ovf),
    .level     (level),
    .count     (count),
    .overflow  (overflow)
  );

  // 10 time-unit clock: rising edges at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [7:0]  sb_q[$];
  logic [15:0] m_count;
  logic        m_ovf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference requantiser: round half up, shift, clamp to 255.
  function automatic logic [7:0] ref_rq(input logic [18:0] v);
    int t;
    t = (int'(v) + (1 << (SHIFT - 1))) >> SHIFT;
    if (t > 255) t = 255;
    return 8'(t);
  endfunction

  task automatic check_state(input bit rdy);
    check_val("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    check_val("level", 32'(level), 32'(sb_q.size()));
    check_val("count", 32'(count), 32'(m_count));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    if (rdy && sb_q.size() != 0) check_val("data", 32'(out_data), 32'(sb_q[0]));
  endtask

  // One clock: drive at the falling edge, check before the rising edge,
  // advance the model, return at the next falling edge.
  task automatic cycle(input bit vin, input logic [18:0] yv, input bit rdy, input bit clr);
    bit pop, push, drop;
    valid_in  = vin;
    y         = yv;
    out_ready = rdy;
    clear_ovf = clr;
    #1;
    check_state(rdy);
    pop  = (sb_q.size() != 0) && rdy;
    push = vin && ((sb_q.size() < DEPTH) || pop);
    drop = vin && !push;
    if (pop) void'(sb_q.pop_front());
    if (push) begin
      sb_q.push_back(ref_rq(yv));
      m_count = m_count + 16'd1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge clock);
  endtask

  task automatic model_clear();
    sb_q.delete();
    m_count = 16'd0;
    m_ovf   = 1'b0;
  endtask

  // Reset pulse applied between edges, released at a falling edge.
  task automatic reset_dut();
    valid_in  = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_state(1'b0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  logic [18:0] rnd_y [6];
  logic [7:0]  rnd_e [6];

  initial begin
    reset     = 1'b0;
    valid_in  = 1'b0;
    y         = 19'd0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    model_clear();

    // Reset state
    #1;
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_data", 32'(out_data), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Rounding and saturation with fixed expected values
    rnd_y[0] = 19'd100;    rnd_e[0] = 8'd13;
    rnd_y[1] = 19'd3;      rnd_e[1] = 8'd0;
    rnd_y[2] = 19'd4;      rnd_e[2] = 8'd1;
    rnd_y[3] = 19'd2043;   rnd_e[3] = 8'd255;
    rnd_y[4] = 19'd2044;   rnd_e[4] = 8'd255;
    rnd_y[5] = 19'd524287; rnd_e[5] = 8'd255;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, rnd_y[i], 1'b1, 1'b0);
      check_val("round_valid", 32'(out_valid), 32'd1);
      check_val("round", 32'(out_data), 32'(rnd_e[i]));
      cycle(1'b0, 19'd0, 1'b1, 1'b0);
    end

    // Ramp: fill to DEPTH without reading, then drain in order
    reset_dut();
    for (int i = 0; i < 8; i++) cycle(1'b1, 19'(8 * (i + 1)), 1'b0, 1'b0);
    check_val("ramp_level", 32'(level), 32'd8);
    check_val("ramp_count", 32'(count), 32'd8);
    check_val("ramp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_val("ramp_data", 32'(out_data), 32'(i + 1));
      cycle(1'b0, 19'd0, 1'b1, 1'b0);
    end
    check_val("ramp_empty", 32'(level), 32'd0);

    // Full plus one extra: drop, overflow, clear, then set-wins-over-clear
    reset_dut();
    for (int i = 0; i < 9; i++) cycle(1'b1, 19'($urandom_range(0, 4000)), 1'b0, 1'b0);
    check_val("full_ovf", 32'(overflow), 32'd1);
    check_val("full_count", 32'(count), 32'd8);
    cycle(1'b0, 19'd0, 1'b0, 1'b1);
    check_val("ovf_cleared", 32'(overflow), 32'd0);
    cycle(1'b1, 19'd77, 1'b0, 1'b1);
    check_val("ovf_set_wins", 32'(overflow), 32'd1);
    cycle(1'b0, 19'd0, 1'b0, 1'b1);

    // Full with simultaneous push and pop, then drain to verify order
    cycle(1'b1, 19'd1000, 1'b1, 1'b0);
    check_val("pp_level", 32'(level), 32'd8);
    check_val("pp_count", 32'(count), 32'd9);
    check_val("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 19'd0, 1'b1, 1'b0);
    check_val("pp_empty", 32'(level), 32'd0);

    // Idle pop request on an empty FIFO
    cycle(1'b0, 19'd0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 19'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0));

    // Reset asserted between edges while level=5
    reset_dut();
    for (int i = 0; i < 5; i++) cycle(1'b1, 19'(i * 40), 1'b0, 1'b0);
    check_val("mid_level_pre", 32'(level), 32'd5);
    reset_dut();
    check_val("mid_level", 32'(level), 32'd0);
    check_val("mid_valid", 32'(out_valid), 32'd0);
    check_val("mid_count", 32'(count), 32'd0);
    cycle(1'b1, 19'd16, 1'b1, 1'b0);
    check_val("post_rst_push", 32'(level), 32'd1);

    // Count wrap over 65536 pushes
    reset_dut();
    for (int i = 0; i < 65536; i++) cycle(1'b1, 19'($urandom), 1'b1, 1'b0);
    check_val("wrap_count", 32'(count), 32'd0);
    check_val("wrap_ovf", 32'(overflow), 32'd0);
    cycle(1'b0, 19'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
